heap_scheduler: RTL and testbench

Shares the single `Memory` heap instance among several program-level requesters, for example independent instruction streams in the `fpga` test harness. It issues one heap action per transaction. It generates the heap's transition-driven clock (`heapClock`) so each operation produces exactly one transition. Fairness between requesters is round-robin. After reset it sequences a heap initialisation (action 1) before serving any requester.

---
 rtl/heap_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/heap_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_heap_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared definitions for the heap scheduler: action codes, FSM state
// encoding and small action-code helpers.
package heap_pkg;

   typedef logic [7:0] heap_action_t;

   localparam heap_action_t HEAP_NOP   = 8'd0;
   localparam heap_action_t HEAP_RESET = 8'd1;
   localparam heap_action_t HEAP_ALLOC = 8'd2;
   localparam heap_action_t HEAP_FREE  = 8'd3;
   localparam heap_action_t HEAP_READ  = 8'd4;
   localparam heap_action_t HEAP_WRITE = 8'd5;

   typedef enum logic [2:0] {
      ST_INIT_SETUP,
      ST_INIT_STROBE,
      ST_INIT_WAIT,
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT,
      ST_DONE
   } heap_state_t;

   // NOP is deliberately illegal for requesters: a transaction must do work.
   function automatic logic heap_action_legal(input heap_action_t a);
      return (a >= HEAP_RESET) && (a <= HEAP_WRITE);
   endfunction

   function automatic logic heap_action_returns_data(input heap_action_t a);
      return (a == HEAP_READ) || (a == HEAP_ALLOC);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector. Picks the first asserted request at or after ptr,
// wrapping modulo REQUESTERS (non-power-of-two counts are fine).
// Ports:
//   req     - request levels
//   ptr     - highest-priority requester index
//   gnt     - one-hot selection (zero when no request)
//   gnt_idx - binary index of the selected requester
//   any     - at least one request asserted
module rr_arbiter #(
   parameter int REQUESTERS = 4,
   parameter int PTR_W      = $clog2(REQUESTERS)
) (
   input  logic [REQUESTERS-1:0] req,
   input  logic [PTR_W-1:0]      ptr,
   output logic [REQUESTERS-1:0] gnt,
   output logic [PTR_W-1:0]      gnt_idx,
   output logic                  any
);

   logic [PTR_W-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         cand = PTR_W'((int'(ptr) + i) % REQUESTERS);
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/heap_scheduler.sv
// Shares one transition-clocked heap among several requesters. After reset it
// issues a heap RESET, then serves requesters round-robin, one heap action per
// transaction, producing exactly one heapClock transition per operation.
// Ports:
//   clock, reset (async, active-low)
//   req/reqAction/reqArray/reqIndex/reqData - packed per-requester requests
//   grant, done, result, error, busy        - requester-side status
//   heapClock/heapAction/heapArray/heapIndex/heapIn, heapOut - heap side
//
// state          | meaning
// ST_INIT_SETUP  | drive RESET action with zero operands
// ST_INIT_STROBE | toggle heapClock for the init transition
// ST_INIT_WAIT   | let the heap settle for LATENCY cycles
// ST_IDLE        | arbitrate; latch grant and operands of the winner
// ST_SETUP       | operands stable; illegal codes finish here with error
// ST_STROBE      | toggle heapClock (visible from the first WAIT cycle)
// ST_WAIT        | LATENCY-cycle down-counter; capture heapOut at terminal count
// ST_DONE        | done pulse, advance round-robin pointer, release grant
module heap_scheduler
   import heap_pkg::*;
#(
   parameter int REQUESTERS = 4,
   parameter int ARRAY_W    = 8,
   parameter int INDEX_W    = 8,
   parameter int DATA_W     = 12,
   parameter int LATENCY    = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [REQUESTERS-1:0]         req,
   input  logic [REQUESTERS*8-1:0]       reqAction,
   input  logic [REQUESTERS*ARRAY_W-1:0] reqArray,
   input  logic [REQUESTERS*INDEX_W-1:0] reqIndex,
   input  logic [REQUESTERS*DATA_W-1:0]  reqData,
   output logic [REQUESTERS-1:0]         grant,
   output logic [REQUESTERS-1:0]         done,
   output logic [DATA_W-1:0]             result,
   output logic                          error,
   output logic                          busy,
   output logic                          heapClock,
   output logic [7:0]                    heapAction,
   output logic [ARRAY_W-1:0]            heapArray,
   output logic [INDEX_W-1:0]            heapIndex,
   output logic [DATA_W-1:0]             heapIn,
   input  logic [DATA_W-1:0]             heapOut
);

   localparam int PTR_W = $clog2(REQUESTERS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   heap_state_t             state_q, state_d;
   logic [REQUESTERS-1:0]   grant_q, grant_d;
   logic [REQUESTERS-1:0]   done_q, done_d;
   logic [PTR_W-1:0]        owner_q, owner_d;
   logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]       result_q, result_d;
   logic                    error_q, error_d;
   logic                    heap_clock_q, heap_clock_d;
   heap_action_t            heap_action_q, heap_action_d;
   logic [ARRAY_W-1:0]      heap_array_q, heap_array_d;
   logic [INDEX_W-1:0]      heap_index_q, heap_index_d;
   logic [DATA_W-1:0]       heap_in_q, heap_in_d;
   logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;

   logic [REQUESTERS-1:0]   arb_gnt;
   logic [PTR_W-1:0]        arb_idx;
   logic                    arb_any;

   heap_action_t            sel_action;
   logic [ARRAY_W-1:0]      sel_array;
   logic [INDEX_W-1:0]      sel_index;
   logic [DATA_W-1:0]       sel_data;

   rr_arbiter #(
      .REQUESTERS (REQUESTERS),
      .PTR_W      (PTR_W)
   ) u_arb (
      .req     (req),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      sel_action = HEAP_NOP;
      sel_array  = '0;
      sel_index  = '0;
      sel_data   = '0;
      for (int r = 0; r < REQUESTERS; r++) begin
         if (arb_idx == PTR_W'(r)) begin
            sel_action = reqAction[r*8 +: 8];
            sel_array  = reqArray[r*ARRAY_W +: ARRAY_W];
            sel_index  = reqIndex[r*INDEX_W +: INDEX_W];
            sel_data   = reqData[r*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      done_d        = '0;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      result_d      = result_q;
      error_d       = 1'b0;
      heap_clock_d  = heap_clock_q;
      heap_action_d = heap_action_q;
      heap_array_d  = heap_array_q;
      heap_index_d  = heap_index_q;
      heap_in_d     = heap_in_q;
      wait_cnt_d    = wait_cnt_q;

      case (state_q)
         ST_INIT_SETUP: begin
            heap_action_d = HEAP_RESET;
            heap_array_d  = '0;
            heap_index_d  = '0;
            heap_in_d     = '0;
            state_d       = ST_INIT_STROBE;
         end
         ST_INIT_STROBE: begin
            heap_clock_d = ~heap_clock_q;
            wait_cnt_d   = CNT_W'(LATENCY - 1);
            state_d      = ST_INIT_WAIT;
         end
         ST_INIT_WAIT: begin
            if (wait_cnt_q == '0) begin
               heap_action_d = HEAP_NOP;
               state_d       = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end
         end
         ST_IDLE: begin
            if (arb_any) begin
               grant_d = arb_gnt;
               owner_d = arb_idx;
               state_d = ST_SETUP;
               // Operands are latched here so they are already stable in SETUP.
               if (heap_action_legal(sel_action)) begin
                  heap_action_d = sel_action;
                  heap_array_d  = sel_array;
                  heap_index_d  = sel_index;
                  heap_in_d     = sel_data;
               end else begin
                  heap_action_d = HEAP_NOP;
                  heap_array_d  = '0;
                  heap_index_d  = '0;
                  heap_in_d     = '0;
               end
            end
         end
         ST_SETUP: begin
            // heap_action_q is NOP exactly when the granted code was illegal.
            if (heap_action_legal(heap_action_q)) begin
               state_d = ST_STROBE;
            end else begin
               done_d   = grant_q;
               error_d  = 1'b1;
               result_d = '0;
               state_d  = ST_DONE;
            end
         end
         ST_STROBE: begin
            heap_clock_d = ~heap_clock_q;
            wait_cnt_d   = CNT_W'(LATENCY - 1);
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_q == '0) begin
               done_d   = grant_q;
               result_d = heap_action_returns_data(heap_action_q) ? heapOut : '0;
               state_d  = ST_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            rr_ptr_d      = (owner_q == PTR_W'(REQUESTERS - 1)) ? '0 : owner_q + PTR_W'(1);
            grant_d       = '0;
            heap_action_d = HEAP_NOP;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_INIT_SETUP;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_INIT_SETUP;
         grant_q       <= '0;
         done_q        <= '0;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         result_q      <= '0;
         error_q       <= 1'b0;
         heap_clock_q  <= 1'b0;
         heap_action_q <= HEAP_NOP;
         heap_array_q  <= '0;
         heap_index_q  <= '0;
         heap_in_q     <= '0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         done_q        <= done_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         result_q      <= result_d;
         error_q       <= error_d;
         heap_clock_q  <= heap_clock_d;
         heap_action_q <= heap_action_d;
         heap_array_q  <= heap_array_d;
         heap_index_q  <= heap_index_d;
         heap_in_q     <= heap_in_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign result     = result_q;
   assign error      = error_q;
   assign busy       = (state_q != ST_IDLE);
   assign heapClock  = heap_clock_q;
   assign heapAction = heap_action_q;
   assign heapArray  = heap_array_q;
   assign heapIndex  = heap_index_q;
   assign heapIn     = heap_in_q;

endmodule

// File: tb/tb_heap_scheduler.sv
module tb_heap_scheduler;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   req;
   logic [31:0]  reqAction;
   logic [31:0]  reqArray;
   logic [31:0]  reqIndex;
   logic [47:0]  reqData;
   logic [3:0]   grant;
   logic [3:0]   done;
   logic [11:0]  result;
   logic         error;
   logic         busy;
   logic         heapClock;
   logic [7:0]   heapAction;
   logic [7:0]   heapArray;
   logic [7:0]   heapIndex;
   logic [11:0]  heapIn;
   logic [11:0]  heapOut;

   heap_scheduler dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .reqAction  (reqAction),
      .reqArray   (reqArray),
      .reqIndex   (reqIndex),
      .reqData    (reqData),
      .grant      (grant),
      .done       (done),
      .result     (result),
      .error      (error),
      .busy       (busy),
      .heapClock  (heapClock),
      .heapAction (heapAction),
      .heapArray  (heapArray),
      .heapIndex  (heapIndex),
      .heapIn     (heapIn),
      .heapOut    (heapOut)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int htog   = 0;
   int done_events = 0;

   always @(heapClock) if (reset === 1'b1) htog++;
   always @(negedge clock) if (done !== 4'b0000) done_events++;

   typedef struct {
      int          r;
      logic [7:0]  act;
      logic [7:0]  arr;
      logic [7:0]  idx;
      logic [11:0] data;
      logic [11:0] hout;
      int          lat;
      logic [11:0] res;
      logic        err;
   } vec_t;

   vec_t vecs[9];

   int got_owner[8];
   int got_cyc[8];
   int ngot;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_slice(input int r, input logic [7:0] a, input logic [7:0] arr,
                            input logic [7:0] idx, input logic [11:0] d);
      reqAction[r*8 +: 8]   = a;
      reqArray[r*8 +: 8]    = arr;
      reqIndex[r*8 +: 8]    = idx;
      reqData[r*12 +: 12]   = d;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int k;
      int t0;
      logic [3:0] oh;
      oh = 4'b0001 << v.r;
      set_slice(v.r, v.act, v.arr, v.idx, v.data);
      heapOut = v.hout;
      t0 = htog;
      req = oh;
      k = 0;
      do begin
         @(negedge clock);
         k++;
         if (k == 1) begin
            chk($sformatf("v%0d_grant", n), grant, oh);
            chk($sformatf("v%0d_heapAction", n), heapAction, v.err ? 8'h00 : v.act);
            if (!v.err) begin
               chk($sformatf("v%0d_heapArray", n), heapArray, v.arr);
               chk($sformatf("v%0d_heapIndex", n), heapIndex, v.idx);
               chk($sformatf("v%0d_heapIn", n), heapIn, v.data);
            end
         end
      end while (done === 4'b0000 && k < 20);
      chk($sformatf("v%0d_done_cycle", n), k, v.lat);
      chk($sformatf("v%0d_done_vec", n), done, oh);
      chk($sformatf("v%0d_result", n), result, v.res);
      chk($sformatf("v%0d_error", n), error, v.err);
      chk($sformatf("v%0d_toggles", n), htog - t0, v.err ? 0 : 1);
      req = 4'b0000;
      @(negedge clock);
      chk($sformatf("v%0d_idle", n), busy, 1'b0);
      chk($sformatf("v%0d_result_hold", n), result, v.res);
      chk($sformatf("v%0d_done_clear", n), done, 4'b0000);
   endtask

   task automatic collect(input int n, input bit drop);
      int k;
      ngot = 0;
      k = 0;
      while (ngot < n && k < 100) begin
         @(negedge clock);
         k++;
         if (done !== 4'b0000) begin
            got_owner[ngot] = oh_idx(done);
            got_cyc[ngot]   = k;
            ngot++;
            if (drop) req = req & ~done;
         end
      end
      chk("seq_count", ngot, n);
   endtask

   initial begin
      int t0;
      vecs[0] = '{1, 8'h04, 8'h03, 8'h05, 12'h000, 12'h0A5, 5, 12'h0A5, 1'b0};
      vecs[1] = '{0, 8'h05, 8'h01, 8'h02, 12'h7FF, 12'h123, 5, 12'h000, 1'b0};
      vecs[2] = '{2, 8'h02, 8'h09, 8'h00, 12'h000, 12'h040, 5, 12'h040, 1'b0};
      vecs[3] = '{3, 8'h09, 8'h04, 8'h04, 12'h111, 12'h3C3, 2, 12'h000, 1'b1};
      vecs[4] = '{0, 8'h00, 8'h00, 8'h00, 12'h000, 12'h555, 2, 12'h000, 1'b1};
      vecs[5] = '{1, 8'h03, 8'h07, 8'h00, 12'h000, 12'hFFF, 5, 12'h000, 1'b0};
      vecs[6] = '{3, 8'h04, 8'hFF, 8'h80, 12'h000, 12'h800, 5, 12'h800, 1'b0};
      vecs[7] = '{1, 8'h06, 8'h01, 8'h01, 12'h001, 12'h777, 2, 12'h000, 1'b1};
      vecs[8] = '{2, 8'h01, 8'h00, 8'h00, 12'h000, 12'hABC, 5, 12'h000, 1'b0};

      reset = 1'b0;
      req = '0; reqAction = '0; reqArray = '0; reqIndex = '0; reqData = '0;
      heapOut = '0;
      repeat (3) @(negedge clock);
      chk("rst_grant", grant, 4'b0000);
      chk("rst_done", done, 4'b0000);
      chk("rst_result", result, 12'h000);
      chk("rst_error", error, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_heapClock", heapClock, 1'b0);
      chk("rst_heapAction", heapAction, 8'h00);
      chk("rst_operands", {heapArray, heapIndex, heapIn}, 28'h0);

      // Initialisation: RESET action, one transition, IDLE at cycle 4.
      reset = 1'b1;
      @(negedge clock);
      chk("init_action", heapAction, 8'h01);
      chk("init_busy1", busy, 1'b1);
      @(negedge clock);
      chk("init_heapClock", heapClock, 1'b1);
      @(negedge clock);
      chk("init_busy3", busy, 1'b1);
      @(negedge clock);
      chk("init_busy4", busy, 1'b0);
      chk("init_action_clear", heapAction, 8'h00);
      chk("init_toggles", htog, 1);
      chk("init_no_done", done_events, 0);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // All four requesting with the pointer at 3 (last owner was 2).
      for (int r = 0; r < 4; r++) set_slice(r, 8'h04, 8'(r), 8'h00, 12'h000);
      heapOut = 12'h03F;
      t0 = htog;
      req = 4'b1111;
      collect(4, 1'b1);
      chk("wrap_owner0", got_owner[0], 3);
      chk("wrap_owner1", got_owner[1], 0);
      chk("wrap_owner2", got_owner[2], 1);
      chk("wrap_owner3", got_owner[3], 2);
      chk("wrap_toggles", htog - t0, 4);
      req = 4'b0000;
      @(negedge clock);

      // Requesters 0 and 2 held continuously alternate, 6 cycles apart.
      t0 = htog;
      req = 4'b0101;
      collect(4, 1'b0);
      req = 4'b0000;
      chk("pair_first_cycle", got_cyc[0], 5);
      chk("pair_owner0", got_owner[0], 0);
      chk("pair_owner1", got_owner[1], 2);
      chk("pair_owner2", got_owner[2], 0);
      chk("pair_owner3", got_owner[3], 2);
      chk("pair_gap1", got_cyc[1] - got_cyc[0], 6);
      chk("pair_gap2", got_cyc[2] - got_cyc[1], 6);
      chk("pair_gap3", got_cyc[3] - got_cyc[2], 6);
      chk("pair_toggles", htog - t0, 4);
      @(negedge clock);

      // Reset during WAIT of a WRITE; request stays held across re-init.
      set_slice(1, 8'h05, 8'h02, 8'h03, 12'h456);
      req = 4'b0010;
      repeat (3) @(negedge clock);
      chk("mid_pre_busy", busy, 1'b1);
      chk("mid_pre_heapClock_toggled", htog - t0, 5);
      reset = 1'b0;
      #1;
      chk("mid_grant", grant, 4'b0000);
      chk("mid_busy", busy, 1'b1);
      chk("mid_heapClock", heapClock, 1'b0);
      chk("mid_heapAction", heapAction, 8'h00);
      chk("mid_operands", {heapArray, heapIndex, heapIn}, 28'h0);
      chk("mid_result", result, 12'h000);
      chk("mid_done", done, 4'b0000);
      @(negedge clock);
      reset = 1'b1;
      t0 = htog;
      collect(1, 1'b1);
      chk("rerun_cycle", got_cyc[0], 9);
      chk("rerun_owner", got_owner[0], 1);
      chk("rerun_toggles", htog - t0, 2);
      chk("rerun_result", result, 12'h000);
      req = 4'b0000;
      @(negedge clock);
      chk("rerun_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
